// File: rtl/tty_pkg.sv
// Shared constants and types for the bus-attached serial transmit device:
// register offsets, STATUS/CTRL bit positions and the transmitter state enum.
package tty_pkg;

    localparam logic [1:0] TTY_DATA   = 2'd0;
    localparam logic [1:0] TTY_STATUS = 2'd1;
    localparam logic [1:0] TTY_CTRL   = 2'd2;
    localparam logic [1:0] TTY_RSVD   = 2'd3;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;

    localparam int CTRL_IE   = 0;
    localparam int CTRL_TXEN = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tty_state_t;

endpackage

// File: rtl/tty_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty
// are ignored, so the caller may request them unconditionally.
module tty_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Fullness/emptiness are judged on the pre-edge count.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/bus_tty_device.sv
// Bus responder exposing DATA/STATUS/CTRL registers in a 4-word window and
// shifting queued bytes out as 8N1 frames on TX, with a drained-FIFO interrupt.
module bus_tty_device
    import tty_pkg::*;
#(
    parameter logic [22:0] BASE       = 23'h7FFFF0,
    parameter int          FIFO_DEPTH = 8,
    parameter int          BAUD_DIV   = 16
) (
    input  logic        _CLK,
    input  logic        _RST,
    input  logic [22:0] BUS_A,
    inout  wire  [15:0] BUS_D,
    input  logic        BUS_R,
    input  logic        BUS_W,
    output logic        TX,
    output logic        IRQ
);

    localparam int CNT_W  = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              bus_w_q;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              ovf_q, ovf_d;
    logic              irq_q;
    tty_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;

    logic              hit, wr_acc, rd_en, push, pop;
    logic [1:0]        offset;
    logic              fifo_full, fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [FCNT_W-1:0] fifo_count;
    logic              cnt_last, start_ok, busy, tx_bit;
    logic [15:0]       rdata;
    logic              unused_bus_bits;

    assign hit    = (BUS_A[22:2] == BASE[22:2]);
    assign offset = BUS_A[1:0];
    // A write is taken only on the rising edge of the strobe; R+W together is a no-op.
    assign wr_acc = BUS_W & ~bus_w_q & hit & ~BUS_R;
    assign rd_en  = BUS_R & ~BUS_W & hit;
    assign push   = wr_acc & (offset == TTY_DATA);
    assign unused_bus_bits = ^BUS_D[15:8];

    tty_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (_CLK),
        .rst_i   (_RST),
        .push_i  (push),
        .wdata_i (BUS_D[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        if (wr_acc && offset == TTY_CTRL)   ctrl_d = BUS_D[1:0];
        if (wr_acc && offset == TTY_STATUS) ovf_d  = 1'b0;
        if (push && fifo_full)              ovf_d  = 1'b1;
    end

    always_ff @(posedge _CLK) begin
        if (_RST) begin
            bus_w_q <= 1'b0;
            ctrl_q  <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            bus_w_q <= BUS_W;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            irq_q   <= ctrl_q[CTRL_IE] & fifo_empty & (state_q == IDLE);
        end
    end

    // Transmitter FSM: state register.
    always_ff @(posedge _CLK) begin
        if (_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign cnt_last = (cnt_q == CNT_W'(BAUD_DIV - 1));
    assign start_ok = ctrl_q[CTRL_TXEN] & ~fifo_empty;

    // Transmitter FSM: next state. STOP chains straight into START when more data waits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (start_ok) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transmitter FSM: outputs.
    always_comb begin
        tx_bit = 1'b1;
        busy   = (state_q != IDLE);
        case (state_q)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shift_q[0];
            default: tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (offset)
                TTY_STATUS: begin
                    rdata[ST_EMPTY]                  = fifo_empty;
                    rdata[ST_FULL]                   = fifo_full;
                    rdata[ST_BUSY]                   = busy;
                    rdata[ST_OVF]                    = ovf_q;
                    rdata[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
                end
                TTY_CTRL: rdata[1:0] = ctrl_q;
                default:  rdata = '0;
            endcase
        end
    end

    assign BUS_D = rd_en ? rdata : 16'hzzzz;
    assign TX    = tx_bit;
    assign IRQ   = irq_q;

endmodule
